// File: rtl/phase_scheduler.sv
// Round-robin green/yellow/all-red scheduler for a signalised intersection.
// Optional emergency preemption is compiled in with `define PREEMPT_EN.
module phase_scheduler #(
  parameter int N_APPROACH  = 4,
  parameter int CNT_W       = 6,
  parameter int T_GREEN_MIN = 10,
  parameter int T_GREEN_MAX = 30,
  parameter int T_YELLOW    = 5,
  parameter int T_ALLRED    = 2,
  localparam int PW = (N_APPROACH > 1) ? $clog2(N_APPROACH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_APPROACH-1:0] req,
`ifdef PREEMPT_EN
  input  logic                  preempt,
  input  logic [PW-1:0]         preempt_idx,
`endif
  output logic [N_APPROACH-1:0] green,
  output logic [N_APPROACH-1:0] yellow,
  output logic [N_APPROACH-1:0] red,
  output logic [PW-1:0]         phase_idx
);

  typedef enum logic [1:0] {
    S_ALLRED,
    S_GREEN,
    S_YELLOW
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MIN = CNT_W'(T_GREEN_MIN);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(T_GREEN_MAX);
  localparam logic [CNT_W-1:0] C_YEL = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] C_AR  = CNT_W'(T_ALLRED);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [PW-1:0]        ptr;

  logic [N_APPROACH-1:0] sel;
  logic                  other_req;
  logic [PW-1:0]         win;
  logic [PW-1:0]         grant;
  logic                  gap;
  logic                  maxo;
  logic                  go;

  assign sel       = N_APPROACH'(1) << ptr;
  assign other_req = |(req & ~sel);

  // Descending scan so the nearest approach after ptr is written last.
  always_comb begin
    int j;
    j   = 0;
    win = '0;
    for (int k = N_APPROACH; k >= 1; k--) begin
      j = (int'(ptr) + k) % N_APPROACH;
      if (req[j]) win = PW'(j);
    end
  end

  assign gap  = other_req && (cnt >= C_MIN) && !req[ptr];
  assign maxo = other_req && (cnt >= C_MAX);

`ifdef PREEMPT_EN
  always_comb begin
    grant = preempt ? preempt_idx : win;
    go    = gap | maxo;
    if (preempt) go = (ptr != preempt_idx);
  end
`else
  assign grant = win;
  assign go    = gap | maxo;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_ALLRED;
      cnt   <= C_ONE;
      ptr   <= PW'(N_APPROACH - 1);
    end else begin
      unique case (state)
        S_ALLRED: begin
          if (cnt == C_AR) begin
            state <= S_GREEN;
            cnt   <= C_ONE;
            ptr   <= grant;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        S_GREEN: begin
          if (go) begin
            state <= S_YELLOW;
            cnt   <= C_ONE;
          end else if (cnt < C_MAX) begin
            cnt <= cnt + C_ONE;
          end
        end
        S_YELLOW: begin
          if (cnt == C_YEL) begin
            state <= S_ALLRED;
            cnt   <= C_ONE;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        default: begin
          state <= S_ALLRED;
          cnt   <= C_ONE;
        end
      endcase
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    red    = '1;
    unique case (state)
      S_GREEN: begin
        green = sel;
        red   = ~sel;
      end
      S_YELLOW: begin
        yellow = sel;
        red    = ~sel;
      end
      default: ;
    endcase
  end

  assign phase_idx = ptr;

endmodule

// File: tb/tb_phase_scheduler.sv
// Randomised check of phase_scheduler against a cycle-level reference model.
// Preemption stimulus is included when PREEMPT_EN is defined.
module tb_phase_scheduler;

  localparam int N    = 4;
  localparam int GMIN = 10;
  localparam int GMAX = 30;
  localparam int TY   = 5;
  localparam int TAR  = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] green, yellow, red;
  logic [1:0]   phase_idx;
`ifdef PREEMPT_EN
  logic         preempt = 1'b0;
  logic [1:0]   preempt_idx = '0;
`endif

  always #5 clk = ~clk;

  phase_scheduler dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
`ifdef PREEMPT_EN
    .preempt(preempt),
    .preempt_idx(preempt_idx),
`endif
    .green(green),
    .yellow(yellow),
    .red(red),
    .phase_idx(phase_idx)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: phase kind (0 all-red, 1 green, 2 yellow), elapsed time, owner
  int m_ph = 0;
  int m_t  = 1;
  int m_g  = N - 1;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic model_step();
    bit leave;
    bit others;
    if (!rst_n) begin
      m_ph = 0; m_t = 1; m_g = N - 1;
      return;
    end
    case (m_ph)
      0: begin
        if (m_t >= TAR) begin
          m_g = pick(req, m_g);
`ifdef PREEMPT_EN
          if (preempt) m_g = int'(preempt_idx);
`endif
          m_ph = 1; m_t = 1;
        end else m_t++;
      end
      1: begin
        others = 0;
        for (int i = 0; i < N; i++)
          if (i != m_g && req[i]) others = 1;
        leave = others && (m_t >= GMAX || (m_t >= GMIN && !req[m_g]));
`ifdef PREEMPT_EN
        if (preempt) leave = (m_g != int'(preempt_idx));
`endif
        if (leave) begin m_ph = 2; m_t = 1; end
        else m_t++;
      end
      default: begin
        if (m_t >= TY) begin m_ph = 0; m_t = 1; end
        else m_t++;
      end
    endcase
  endtask

  task automatic compare();
    logic [N-1:0] oh;
    logic [N-1:0] eg, ey, er;
    oh = '0;
    oh[m_g] = 1'b1;
    eg = (m_ph == 1) ? oh : '0;
    ey = (m_ph == 2) ? oh : '0;
    er = (m_ph == 0) ? '1 : ~oh;
    chk("green", 32'(green), 32'(eg));
    chk("yellow", 32'(yellow), 32'(ey));
    chk("red", 32'(red), 32'(er));
    chk("phase_idx", 32'(phase_idx), 32'(m_g));
    chk("onehot", 32'($countones(green | yellow) <= 1), 32'(1));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    // Reset for two cycles with no demand, then rest on approach 0
    rst_n = 1'b0;
    req   = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (120) cycle();
    // Side-street call while resting saturated
    req = 4'b0100;
    repeat (60) cycle();
    // Continuous demand on 1..3: max-out rotation
    req = 4'b1110;
    repeat (200) cycle();
    // Drop own request early: gap-out
    req = 4'b1000;
    repeat (60) cycle();
    req = 4'b0010;
    repeat (60) cycle();
    // Reset pulse mid-phase
    req = 4'b1111;
    repeat (43) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (40) cycle();
    // Randomised segments
    for (int s = 0; s < 80; s++) begin
      int len;
      int mode;
      logic [N-1:0] base;
      len  = $urandom_range(10, 90);
      mode = $urandom_range(0, 3);
      base = N'($urandom_range(0, 15));
`ifdef PREEMPT_EN
      preempt     = ($urandom_range(0, 4) == 0);
      preempt_idx = 2'($urandom_range(0, 3));
`endif
      for (int c = 0; c < len; c++) begin
        case (mode)
          0: req = base;
          1: req = N'($urandom);
          2: req = ($urandom_range(0, 7) == 0) ? N'($urandom) : base;
          default: req = '0;
        endcase
        rst_n = ($urandom_range(0, 399) != 0);
        cycle();
      end
    end
    rst_n = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
